clock_gen: RTL and testbench
============================

# clock_gen

Parametrised strobe and fractional clock generator; successor to the fixed 28 MHz strobe block. It produces a one-hot phase ring of configurable length, the derived half-rate and half-ring strobes, and NCH independent phase-accumulator (NCO) clock channels with run-time programmable increments. It sits at the top of the clock tree and feeds the CPU/video strobes and the sound-chip (AY/TS/SAA) clock enables.

## Interface
- PHASES, default 4: length of the one-hot phase ring; must be even and ≥ 2.
- NCH, default 2: number of fractional clock channels; ≥ 1.
- ACC_W, default 16: accumulator and increment width per channel; ≥ 4.

- clk  input  1  system clock, 28 MHz nominal.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- ph  output  PHASES  one-hot phase ring; ph[0] is the first phase.
- f  output  2  f[0]/f[1]: clk/2 toggles, 180° apart.
- half  output  2  half[0] high for ring positions 0..PHASES/2-1; half[1] is its inverse.
- ch_inc  input  NCH*ACC_W  increment for channel i in bits [i*ACC_W +: ACC_W].
- ch_load  input  NCH  load strobe: copy ch_inc slice into the channel's increment register.
- ch_en  input  NCH  channel run enable.
- ch_sync  input  1  zero all accumulators simultaneously.
- ch_clk  output  NCH  channel clock: accumulator MSB.
- ch_stb  output  NCH  one-cycle strobe coincident with each ch_clk rising edge.

## Operation
- Reset (asynchronous, immediate on rst_n low): ph = 1 (only ph[0] set), f = 2'b01, half = 2'b01, every accumulator = 0, every increment register = 0, ch_clk = 0, ch_stb = 0.
- Phase ring: ph rotates left by one every clk; ph[PHASES-1] wraps to ph[0]. f inverts every clk. half is registered and updated together with ph, so half[0] = 1 whenever the set ph bit index < PHASES/2.
- Increment register: on an edge with ch_load[i] = 1, inc[i] takes ch_inc slice i. The add on that same edge uses the old inc[i]; the new value is used from the next edge on.
- Accumulator, per channel, priority order at each edge:
  1. ch_sync = 1: acc = 0, ch_stb = 0 (overrides ch_en; a coincident ch_load is still performed).
  2. ch_en[i] = 0: acc holds, ch_clk holds, ch_stb = 0.
  3. Otherwise: acc = (acc + inc) mod 2^ACC_W; the carry-out is discarded.
- ch_clk[i] = acc[i][ACC_W-1] (register output, no glitches).
- ch_stb[i] = 1 for exactly the cycle in which acc MSB has just changed 0→1 on an advancing edge.
- Output frequency = f_clk × inc / 2^ACC_W (÷PHASES when gated, see Configuration). inc = 0 freezes the channel. inc ≥ 2^(ACC_W-1) aliases; no saturation or guard is applied.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- ch_load to first use: 1 edge. Advance to ch_clk/ch_stb: same edge (acc and ch_stb update together).
- ch_sync: takes effect on the sampling edge. The first post-sync ch_stb for each channel occurs after ceil(2^(ACC_W-1)/inc) advances. Channels with equal inc are therefore phase-aligned.
- Reset deassertion is not synchronised inside the block. The driver deasserts rst_n synchronously to clk.

## Configuration
- CLOCK_GEN_GATED_EN defined: accumulators advance only on edges where ph[0] = 1, i.e. once per ring turn. ch_en, ch_sync and ch_load behave as above, but hold/advance applies only on those edges. ch_sync and ch_load are still honoured on every edge.
- Undefined: accumulators advance on every clk edge where enabled.

## Test plan
- Reset release, PHASES=4: ph reads 0001, 0010, 0100, 1000, 0001; f[0] reads 1,0,1,0; half[0] reads 1,1,0,0 repeating.
- NCH=2, ACC_W=16, ungated: load inc0 = 16'h1000 with en. ch_clk[0] rises 8 edges after the first new-inc add. Thereafter the period is 16 clk (8 high / 8 low), with ch_stb[0] every 16 clk (1.75 MHz at 28 MHz).
- inc1 = 16'h8000: ch_clk[1] toggles every clk, ch_stb[1] fires every 2 clk. Reload inc1 = 16'h2000 mid-run: the period changes to 8 clk starting at the edge after the load edge.
- Drop ch_en[0] for 5 cycles with acc = 16'h3000: acc, ch_clk and ch_stb are held/0. On re-enable, acc continues from 16'h3000.
- Run inc0 = 16'h1000 and inc1 = 16'h1000 from different phases, then pulse ch_sync: both acc = 0, and both ch_stb fire on the same edge 8 advances later. Also pulse ch_sync with ch_en = 0: acc = 0.
- Assert rst_n low mid-period, between edges: all outputs reach reset values before the next clk edge. With CLOCK_GEN_GATED_EN and inc = 16'h8000, ch_clk toggles every 4 clk.

Source files
------------

// File: rtl/clock_gen.sv
// Phase ring, half-rate/half-ring strobes and NCH phase-accumulator clock channels.
// Optional CLOCK_GEN_GATED_EN: accumulators advance only on edges where ph[0] is set.
module clock_gen #(
    parameter int PHASES = 4,
    parameter int NCH    = 2,
    parameter int ACC_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [PHASES-1:0]      ph,
    output logic [1:0]             f,
    output logic [1:0]             half,
    input  logic [NCH*ACC_W-1:0]   ch_inc,
    input  logic [NCH-1:0]         ch_load,
    input  logic [NCH-1:0]         ch_en,
    input  logic                   ch_sync,
    output logic [NCH-1:0]         ch_clk,
    output logic [NCH-1:0]         ch_stb
);

    logic [PHASES-1:0] ph_next;
    logic              half_next;
    logic              tick;

    assign ph_next   = {ph[PHASES-2:0], ph[PHASES-1]};
    // half follows the ring position that ph is about to take
    assign half_next = |ph_next[PHASES/2-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph   <= PHASES'(1);
            f    <= 2'b01;
            half <= 2'b01;
        end else begin
            ph   <= ph_next;
            f    <= ~f;
            half <= {~half_next, half_next};
        end
    end

`ifdef CLOCK_GEN_GATED_EN
    assign tick = ph[0];
`else
    assign tick = 1'b1;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [ACC_W-1:0] acc;
        logic [ACC_W-1:0] inc;
        logic [ACC_W-1:0] sum;
        logic             stb;

        assign sum = acc + inc;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc <= '0;
                inc <= '0;
                stb <= 1'b0;
            end else begin
                if (ch_load[i])
                    inc <= ch_inc[i*ACC_W +: ACC_W];
                if (ch_sync) begin
                    acc <= '0;
                    stb <= 1'b0;
                end else if (ch_en[i] && tick) begin
                    acc <= sum;
                    stb <= ~acc[ACC_W-1] & sum[ACC_W-1];
                end else begin
                    stb <= 1'b0;
                end
            end
        end

        assign ch_clk[i] = acc[ACC_W-1];
        assign ch_stb[i] = stb;
    end

endmodule

// File: tb/tb_clock_gen.sv
// Randomised and directed bench for clock_gen against an arithmetic reference model.
module tb_clock_gen;

    localparam int PHASES = 4;
    localparam int NCH    = 2;
    localparam int ACC_W  = 16;
    localparam longint unsigned MOD  = 64'd1 << ACC_W;
    localparam longint unsigned HALF = 64'd1 << (ACC_W - 1);

    logic                 clk;
    logic                 rst_n;
    logic [PHASES-1:0]    ph;
    logic [1:0]           f;
    logic [1:0]           half;
    logic [NCH*ACC_W-1:0] ch_inc;
    logic [NCH-1:0]       ch_load;
    logic [NCH-1:0]       ch_en;
    logic                 ch_sync;
    logic [NCH-1:0]       ch_clk;
    logic [NCH-1:0]       ch_stb;

    clock_gen #(.PHASES(PHASES), .NCH(NCH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .ph(ph), .f(f), .half(half),
        .ch_inc(ch_inc), .ch_load(ch_load), .ch_en(ch_en), .ch_sync(ch_sync),
        .ch_clk(ch_clk), .ch_stb(ch_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    longint unsigned m_acc [NCH];
    longint unsigned m_inc [NCH];
    bit              m_stb [NCH];
    int              m_pos;
    int              m_n;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = 0;
            m_stb[i] = 0;
        end
        m_pos = 0;
        m_n   = 0;
    endtask

    task automatic model_edge();
        bit gate;
`ifdef CLOCK_GEN_GATED_EN
        gate = (m_pos == 0);
`else
        gate = 1'b1;
`endif
        for (int i = 0; i < NCH; i++) begin
            longint unsigned na;
            if (ch_sync) begin
                m_acc[i] = 0;
                m_stb[i] = 0;
            end else if (ch_en[i] && gate) begin
                na       = (m_acc[i] + m_inc[i]) % MOD;
                m_stb[i] = (m_acc[i] < HALF) && (na >= HALF);
                m_acc[i] = na;
            end else begin
                m_stb[i] = 0;
            end
            if (ch_load[i])
                m_inc[i] = longint'(ch_inc[i*ACC_W +: ACC_W]);
        end
        m_pos = (m_pos + 1) % PHASES;
        m_n++;
    endtask

    task automatic compare_all();
        logic [PHASES-1:0] e_ph;
        logic [NCH-1:0]    e_clk;
        logic [NCH-1:0]    e_stb;
        e_ph = '0;
        e_ph[m_pos] = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            e_clk[i] = (m_acc[i] >= HALF);
            e_stb[i] = m_stb[i];
        end
        check_eq("ph", 64'(ph), 64'(e_ph));
        check_eq("f", 64'(f), (m_n % 2 == 0) ? 64'd1 : 64'd2);
        check_eq("half", 64'(half), (m_pos < PHASES / 2) ? 64'd1 : 64'd2);
        check_eq("ch_clk", 64'(ch_clk), 64'(e_clk));
        check_eq("ch_stb", 64'(ch_stb), 64'(e_stb));
    endtask

    task automatic set_inc(input int ch, input logic [ACC_W-1:0] v);
        ch_inc[ch*ACC_W +: ACC_W] = v;
    endtask

    task automatic step(input logic [NCH-1:0] ld, input logic [NCH-1:0] en, input logic sy);
        ch_load = ld;
        ch_en   = en;
        ch_sync = sy;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ph"}, 64'(ph), 64'd1);
        check_eq({tag, "_f"}, 64'(f), 64'd1);
        check_eq({tag, "_half"}, 64'(half), 64'd1);
        check_eq({tag, "_clk"}, 64'(ch_clk), 64'd0);
        check_eq({tag, "_stb"}, 64'(ch_stb), 64'd0);
    endtask

    initial begin
        int first;
        int second;
        rst_n   = 1'b0;
        ch_inc  = '0;
        ch_load = '0;
        ch_en   = '0;
        ch_sync = 1'b0;
        model_reset();
        #12;
        check_reset_values("reset");
        @(negedge clk) rst_n = 1'b1;

        // ring, f and half sequence
        for (int k = 0; k < 8; k++) step('0, '0, 1'b0);

`ifndef CLOCK_GEN_GATED_EN
        // inc0 = 0x1000, inc1 = 0x8000; add on the load edge uses the old zero increment
        set_inc(0, 16'h1000);
        set_inc(1, 16'h8000);
        step(2'b11, 2'b11, 1'b0);
        first = -1;
        second = -1;
        for (int k = 1; k <= 40; k++) begin
            step('0, 2'b11, 1'b0);
            if (ch_stb[0]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check_eq("inc0_first_stb", 64'(first), 64'd8);
        check_eq("inc0_period", 64'(second - first), 64'd16);

        // reload inc1 mid-run
        set_inc(1, 16'h2000);
        step(2'b10, 2'b11, 1'b0);
        first = -1;
        second = -1;
        for (int k = 1; k <= 24; k++) begin
            step('0, 2'b11, 1'b0);
            if (ch_stb[1]) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check_eq("inc1_reload_period", 64'(second - first), 64'd8);

        // hold at acc0 = 0x3000
        step('0, 2'b11, 1'b1);
        for (int k = 0; k < 3; k++) step('0, 2'b11, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step('0, 2'b10, 1'b0);
            check_eq("hold_stb0", 64'(ch_stb[0]), 64'd0);
            check_eq("hold_clk0", 64'(ch_clk[0]), 64'd0);
        end
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            step('0, 2'b11, 1'b0);
            if (ch_stb[0] && first < 0) first = k;
        end
        check_eq("resume_from_3000", 64'(first), 64'd5);

        // equal increments from different phases, then sync
        set_inc(1, 16'h1000);
        step(2'b10, 2'b11, 1'b0);
        for (int k = 0; k < 3; k++) step('0, 2'b01, 1'b0);
        step('0, 2'b11, 1'b1);
        for (int k = 1; k <= 8; k++) step('0, 2'b11, 1'b0);
        check_eq("sync_align", 64'(ch_stb), 64'd3);

        // sync while disabled
        for (int k = 0; k < 5; k++) step('0, 2'b11, 1'b0);
        step('0, 2'b00, 1'b1);
        for (int k = 1; k <= 8; k++) step('0, 2'b11, 1'b0);
        check_eq("sync_disabled_align", 64'(ch_stb), 64'd3);
`else
        // gated: inc = 0x8000 toggles ch_clk once per ring turn
        set_inc(0, 16'h8000);
        step(2'b01, 2'b01, 1'b1);
        first = -1;
        second = -1;
        for (int k = 1; k <= 24; k++) begin
            logic prev;
            prev = ch_clk[0];
            step('0, 2'b01, 1'b0);
            if (ch_clk[0] != prev) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        check_eq("gated_toggle", 64'(second - first), 64'(PHASES));
`endif

        // randomised traffic
        for (int k = 0; k < 600; k++) begin
            logic [NCH-1:0] ld;
            logic [NCH-1:0] en;
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 1) == 0)
                    set_inc(i, ACC_W'($urandom_range(0, 16'h3FFF)));
                else
                    set_inc(i, ACC_W'($urandom_range(0, 16'hFFFF)));
                ld[i] = ($urandom_range(0, 15) == 0);
                en[i] = ($urandom_range(0, 7) != 0);
            end
            step(ld, en, $urandom_range(0, 49) == 0);
        end

        // asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_rst");
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step('0, 2'b11, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
